// File: rtl/core_wb_arb_if.sv
// Writeback arbiter bus bundle: ALU and LSU result channels, register-file write port, pending mask.
// The fwd_* bypass signals exist only when CORE_WB_FWD_EN is defined.
interface core_wb_arb_if;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 16;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;
    logic [1:0]        lsu_size;
    logic [1:0]        lsu_off;
    logic              lsu_signed;

    logic              wb;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [NREG-1:0]   pend_mask;

`ifdef CORE_WB_FWD_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
`endif

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data, lsu_size, lsu_off, lsu_signed,
        input  alu_ready, lsu_ready, wb, wb_addr, wb_data,
`ifdef CORE_WB_FWD_EN
        input  fwd_valid, fwd_addr, fwd_data,
`endif
        input  pend_mask
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data, lsu_size, lsu_off, lsu_signed,
        output alu_ready, lsu_ready, wb, wb_addr, wb_data,
`ifdef CORE_WB_FWD_EN
        output fwd_valid, fwd_addr, fwd_data,
`endif
        output pend_mask
    );
endinterface

// File: rtl/core_wb_arb.sv
// Writeback arbiter: merges ALU results and extended load returns onto the single register-file write port.
// Optional execute-stage bypass outputs (fwd_*) are enabled by defining CORE_WB_FWD_EN.
module core_wb_arb #(
    parameter int unsigned LSU_DEPTH = 2
) (
    input logic          clk,
    input logic          rst_n,
    core_wb_arb_if.slave bus
);
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 16;
    localparam int unsigned PTR_W  = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t         mem_q [LSU_DEPTH];
    wb_entry_t         mem_d [LSU_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  scan_ptr_c;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              wb_q, wb_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              full_c, empty_c;
    logic              push_c, pop_c, sel_alu_c;
    logic              alu_ready_c, lsu_ready_c;
    logic [NREG-1:0]   pend_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    wb_entry_t         push_entry_c, head_c, win_c;

    // Load alignment and extension, applied before the entry enters the FIFO.
    always_comb begin
        byte_c = bus.lsu_data[7:0];
        case (bus.lsu_off)
            2'd0:    byte_c = bus.lsu_data[7:0];
            2'd1:    byte_c = bus.lsu_data[15:8];
            2'd2:    byte_c = bus.lsu_data[23:16];
            default: byte_c = bus.lsu_data[31:24];
        endcase
        half_c = bus.lsu_off[1] ? bus.lsu_data[31:16] : bus.lsu_data[15:0];

        push_entry_c.addr = bus.lsu_addr;
        case (bus.lsu_size)
            2'd0:    push_entry_c.data = {{(DATA_W-8){bus.lsu_signed & byte_c[7]}}, byte_c};
            2'd1:    push_entry_c.data = {{(DATA_W-16){bus.lsu_signed & half_c[15]}}, half_c};
            default: push_entry_c.data = bus.lsu_data;
        endcase
    end

    // Occupancy, pending-write mask and arbitration.
    always_comb begin
        full_c     = (count_q == CNT_W'(LSU_DEPTH));
        empty_c    = (count_q == '0);
        head_c     = mem_q[rd_ptr_q];

        pend_c     = '0;
        scan_ptr_c = rd_ptr_q;
        for (int unsigned i = 0; i < LSU_DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                pend_c[mem_q[scan_ptr_c].addr] = 1'b1;
            end
            scan_ptr_c = scan_ptr_c + PTR_W'(1);
        end
        if (wb_q) begin
            pend_c[wb_addr_q] = 1'b1;
        end

        // A full FIFO blocks the ALU so the head always wins; WAW blocks on any pending write.
        alu_ready_c = rst_n && !full_c && !pend_c[bus.alu_addr];
        lsu_ready_c = rst_n && !full_c;
        push_c      = bus.lsu_valid && lsu_ready_c;
        sel_alu_c   = bus.alu_valid && alu_ready_c;
        pop_c       = rst_n && !sel_alu_c && !empty_c;

        if (sel_alu_c) begin
            win_c.addr = bus.alu_addr;
            win_c.data = bus.alu_data;
        end else begin
            win_c = head_c;
        end
    end

    // Next-state for FIFO storage, pointers and the write-port register.
    always_comb begin
        mem_d = mem_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = push_entry_c;
        end
        wr_ptr_d  = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        wb_d      = sel_alu_c || pop_c;
        wb_addr_d = wb_d ? win_c.addr : wb_addr_q;
        wb_data_d = wb_d ? win_c.data : wb_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LSU_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_q      <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wb_q      <= wb_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.alu_ready = alu_ready_c;
    assign bus.lsu_ready = lsu_ready_c;
    assign bus.wb        = wb_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.pend_mask = pend_c;

`ifdef CORE_WB_FWD_EN
    // Same-cycle view of the winner for execute-stage bypass.
    assign bus.fwd_valid = rst_n && wb_d;
    assign bus.fwd_addr  = (rst_n && wb_d) ? win_c.addr : '0;
    assign bus.fwd_data  = (rst_n && wb_d) ? win_c.data : '0;
`endif
endmodule

// File: tb/tb_core_wb_arb.sv
// Directed bench for core_wb_arb: extension vector table plus hand-written arbitration, WAW and reset sequences.
module tb_core_wb_arb;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   wb_cnt;
    logic [31:0] rf [16];

    core_wb_arb_if bus ();

    core_wb_arb #(.LSU_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  size;
        logic [1:0]  off;
        logic        sgn;
        logic [31:0] data;
        logic [31:0] exp;
    } ext_vec_t;

    ext_vec_t vecs [11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model observes writes mid-cycle.
    always @(negedge clk) begin
        if (bus.wb === 1'b1) begin
            rf[bus.wb_addr] <= bus.wb_data;
            wb_cnt <= wb_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_addr   = '0;
        bus.alu_data   = '0;
        bus.lsu_valid  = 1'b0;
        bus.lsu_addr   = '0;
        bus.lsu_data   = '0;
        bus.lsu_size   = 2'd2;
        bus.lsu_off    = '0;
        bus.lsu_signed = 1'b0;
    endtask

    task automatic drive_alu(input logic [3:0] a, input logic [31:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    task automatic drive_lsu_word(input logic [3:0] a, input logic [31:0] d);
        bus.lsu_valid  = 1'b1;
        bus.lsu_addr   = a;
        bus.lsu_data   = d;
        bus.lsu_size   = 2'd2;
        bus.lsu_off    = 2'd0;
        bus.lsu_signed = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_mask;
        tests  = 0;
        fails  = 0;
        wb_cnt = 0;
        for (int r = 0; r < 16; r++) rf[r] = '0;

        vecs[0]  = '{2'd0, 2'd1, 1'b1, 32'h80F17F82, 32'h0000007F};
        vecs[1]  = '{2'd0, 2'd0, 1'b1, 32'h80F17F82, 32'hFFFFFF82};
        vecs[2]  = '{2'd1, 2'd2, 1'b0, 32'h80F17F82, 32'h000080F1};
        vecs[3]  = '{2'd2, 2'd3, 1'b1, 32'h80F17F82, 32'h80F17F82};
        vecs[4]  = '{2'd0, 2'd3, 1'b0, 32'h80F17F82, 32'h00000080};
        vecs[5]  = '{2'd0, 2'd3, 1'b1, 32'h80F17F82, 32'hFFFFFF80};
        vecs[6]  = '{2'd1, 2'd3, 1'b1, 32'h80F17F82, 32'hFFFF80F1};
        vecs[7]  = '{2'd1, 2'd0, 1'b1, 32'h80F17F82, 32'h00007F82};
        vecs[8]  = '{2'd3, 2'd1, 1'b0, 32'h80F17F82, 32'h80F17F82};
        vecs[9]  = '{2'd1, 2'd1, 1'b1, 32'h80F17F82, 32'h00007F82};
        vecs[10] = '{2'd0, 2'd2, 1'b1, 32'h80F17F82, 32'hFFFFFFF1};

        // Reset state with both requesters offering.
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        drive_alu(4'd3, 32'h1);
        drive_lsu_word(4'd2, 32'h2);
        #1;
        check("rst_wb", 32'(bus.wb), 32'h0);
        check("rst_wb_addr", 32'(bus.wb_addr), 32'h0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_pend", 32'(bus.pend_mask), 32'h0);
        check("rst_alu_ready", 32'(bus.alu_ready), 32'h0);
        check("rst_lsu_ready", 32'(bus.lsu_ready), 32'h0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();

        // ALU only.
        drive_alu(4'd3, 32'hDEADBEEF);
        #1;
        check("alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        idle_inputs();
        #1;
        check("alu_wb", 32'(bus.wb), 32'h1);
        check("alu_wb_addr", 32'(bus.wb_addr), 32'h3);
        check("alu_wb_data", bus.wb_data, 32'hDEADBEEF);
        step();
        check("alu_wb_off", 32'(bus.wb), 32'h0);

        // Load extension table.
        for (int i = 0; i < 11; i++) begin
            bus.lsu_valid  = 1'b1;
            bus.lsu_addr   = 4'(i + 1);
            bus.lsu_data   = vecs[i].data;
            bus.lsu_size   = vecs[i].size;
            bus.lsu_off    = vecs[i].off;
            bus.lsu_signed = vecs[i].sgn;
            #1;
            check($sformatf("ext%0d_lsu_ready", i), 32'(bus.lsu_ready), 32'h1);
            step();
            idle_inputs();
            #1;
            exp_mask = 16'h1 << (i + 1);
            check($sformatf("ext%0d_fifo_wb", i), 32'(bus.wb), 32'h0);
            check($sformatf("ext%0d_pend", i), 32'(bus.pend_mask), 32'(exp_mask));
            step();
            check($sformatf("ext%0d_wb", i), 32'(bus.wb), 32'h1);
            check($sformatf("ext%0d_wb_addr", i), 32'(bus.wb_addr), 32'(i + 1));
            check($sformatf("ext%0d_wb_data", i), bus.wb_data, vecs[i].exp);
            step();
            check($sformatf("ext%0d_wb_off", i), 32'(bus.wb), 32'h0);
        end

        // Priority and full: ALU wins while not full, then r1/r2 drain.
        drive_alu(4'd5, 32'hA5);
        drive_lsu_word(4'd1, 32'h11);
        #1;
        check("pri_a_alu_ready", 32'(bus.alu_ready), 32'h1);
        check("pri_a_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        step();
        drive_alu(4'd6, 32'hA6);
        drive_lsu_word(4'd2, 32'h22);
        #1;
        check("pri_b_wb_addr", 32'(bus.wb_addr), 32'h5);
        check("pri_b_wb_data", bus.wb_data, 32'hA5);
        check("pri_b_pend", 32'(bus.pend_mask), 32'h0022);
        check("pri_b_alu_ready", 32'(bus.alu_ready), 32'h1);
        check("pri_b_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        step();
        drive_alu(4'd5, 32'hB5);
        drive_lsu_word(4'd9, 32'h99);
        #1;
        check("pri_c_wb_addr", 32'(bus.wb_addr), 32'h6);
        check("pri_c_pend", 32'(bus.pend_mask), 32'h0046);
        check("pri_c_alu_ready", 32'(bus.alu_ready), 32'h0);
        check("pri_c_lsu_ready", 32'(bus.lsu_ready), 32'h0);
        step();
        bus.lsu_valid = 1'b0;
        #1;
        check("pri_d_wb", 32'(bus.wb), 32'h1);
        check("pri_d_wb_addr", 32'(bus.wb_addr), 32'h1);
        check("pri_d_wb_data", bus.wb_data, 32'h11);
        check("pri_d_pend", 32'(bus.pend_mask), 32'h0006);
        check("pri_d_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        check("pri_d_alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        idle_inputs();
        #1;
        check("pri_e_wb_addr", 32'(bus.wb_addr), 32'h5);
        check("pri_e_wb_data", bus.wb_data, 32'hB5);
        check("pri_e_pend", 32'(bus.pend_mask), 32'h0024);
        step();
        check("pri_f_wb", 32'(bus.wb), 32'h1);
        check("pri_f_wb_addr", 32'(bus.wb_addr), 32'h2);
        check("pri_f_wb_data", bus.wb_data, 32'h22);
        check("pri_f_pend", 32'(bus.pend_mask), 32'h0004);
        step();
        check("pri_g_wb", 32'(bus.wb), 32'h0);
        check("pri_g_pend", 32'(bus.pend_mask), 32'h0);

        // WAW: ALU to r4 waits for the buffered load to r4.
        drive_lsu_word(4'd4, 32'h44);
        step();
        bus.lsu_valid = 1'b0;
        drive_alu(4'd4, 32'h99);
        #1;
        check("waw_q_alu_ready", 32'(bus.alu_ready), 32'h0);
        check("waw_q_pend", 32'(bus.pend_mask), 32'h0010);
        step();
        check("waw_r_wb_data", bus.wb_data, 32'h44);
        check("waw_r_alu_ready", 32'(bus.alu_ready), 32'h0);
        check("waw_r_pend", 32'(bus.pend_mask), 32'h0010);
        step();
        check("waw_s_wb", 32'(bus.wb), 32'h0);
        check("waw_s_pend", 32'(bus.pend_mask), 32'h0);
        check("waw_s_alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        idle_inputs();
        #1;
        check("waw_t_wb_addr", 32'(bus.wb_addr), 32'h4);
        check("waw_t_wb_data", bus.wb_data, 32'h99);
        step();
        check("waw_rf4", rf[4], 32'h99);

`ifdef CORE_WB_FWD_EN
        // Bypass carries the winner one cycle ahead of wb.
        drive_alu(4'd7, 32'h77777777);
        #1;
        check("fwd_valid", 32'(bus.fwd_valid), 32'h1);
        check("fwd_addr", 32'(bus.fwd_addr), 32'h7);
        check("fwd_data", bus.fwd_data, 32'h77777777);
        check("fwd_wb_before", 32'(bus.wb), 32'h0);
        step();
        idle_inputs();
        #1;
        check("fwd_wb_after", 32'(bus.wb), 32'h1);
        check("fwd_wb_addr", 32'(bus.wb_addr), 32'h7);
        check("fwd_valid_idle", 32'(bus.fwd_valid), 32'h0);
        step();
`endif

        // Reset mid-traffic with two loads buffered.
        drive_alu(4'd10, 32'hAA);
        drive_lsu_word(4'd11, 32'hBB);
        step();
        drive_alu(4'd12, 32'hCC);
        drive_lsu_word(4'd13, 32'hDD);
        #1;
        check("mrst_fill_alu_ready", 32'(bus.alu_ready), 32'h1);
        step();
        drive_alu(4'd14, 32'hEE);
        drive_lsu_word(4'd9, 32'h99);
        #1;
        check("mrst_full_lsu_ready", 32'(bus.lsu_ready), 32'h0);
        check("mrst_full_pend", 32'(bus.pend_mask), 32'h3800);
        rst_n = 1'b0;
        #1;
        check("mrst_wb", 32'(bus.wb), 32'h0);
        check("mrst_wb_addr", 32'(bus.wb_addr), 32'h0);
        check("mrst_wb_data", bus.wb_data, 32'h0);
        check("mrst_pend", 32'(bus.pend_mask), 32'h0);
        check("mrst_alu_ready", 32'(bus.alu_ready), 32'h0);
        check("mrst_lsu_ready", 32'(bus.lsu_ready), 32'h0);
        idle_inputs();
        step();
        step();
        rst_n  = 1'b1;
        wb_cnt = 0;
        #1;
        check("mrst_rel_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mrst_stale_wb%0d", k), 32'(bus.wb), 32'h0);
        end
        check("mrst_wb_count", 32'(wb_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
